// File: rtl/vx_reorder_buffer_pkg.sv
// Shared helpers for the reorder buffer: tag-width derivation and the
// occupancy-counter operation encoding.
package vx_reorder_buffer_pkg;

    // Width needed to address n entries, never less than one bit.
    function automatic int unsigned vx_log2up(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // What the occupancy counter does in a given cycle.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/vx_reorder_buffer_dp_ram.sv
// Payload store for the reorder buffer: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module vx_reorder_buffer_dp_ram #(
    parameter int DATAW  = 1,
    parameter int SIZE   = 4,
    parameter int ADDRW  = 2,
    parameter int LUTRAM = 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ADDRW-1:0] waddr_i,
    input  logic [DATAW-1:0] wdata_i,
    input  logic [ADDRW-1:0] raddr_i,
    output logic [DATAW-1:0] rdata_o
);

    generate
        if (LUTRAM != 0) begin : g_lutram
            (* ram_style = "distributed" *) logic [DATAW-1:0] mem_q [SIZE];

            // Write the arriving payload into its slot.
            always_ff @(posedge clk_i) begin
                if (we_i) begin
                    mem_q[waddr_i] <= wdata_i;
                end
            end

            assign rdata_o = mem_q[raddr_i];
        end else begin : g_flop
            (* ram_style = "registers" *) logic [DATAW-1:0] mem_q [SIZE];

            // Write the arriving payload into its slot.
            always_ff @(posedge clk_i) begin
                if (we_i) begin
                    mem_q[waddr_i] <= wdata_i;
                end
            end

            assign rdata_o = mem_q[raddr_i];
        end
    endgenerate

endmodule

// File: rtl/vx_reorder_buffer.sv
// Reorder buffer: hands out tags in ring order, accepts out-of-order
// completions against those tags, and releases entries strictly in
// allocation order once the oldest one has completed.
module vx_reorder_buffer
    import vx_reorder_buffer_pkg::*;
#(
    parameter int DATAW  = 1,
    parameter int SIZE   = 4,
    parameter int ADDRW  = int'(vx_log2up(SIZE)),
    parameter int LUTRAM = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_valid_i,
    output logic             alloc_ready_o,
    output logic [ADDRW-1:0] alloc_tag_o,
    input  logic             fill_valid_i,
    input  logic [ADDRW-1:0] fill_tag_i,
    input  logic [DATAW-1:0] fill_data_i,
    output logic             deq_valid_o,
    output logic [ADDRW-1:0] deq_tag_o,
    output logic [DATAW-1:0] deq_data_o,
    input  logic             deq_ready_i,
    output logic             empty_o,
    output logic             full_o
);

    localparam int              CNTW = ADDRW + 1;
    localparam logic [ADDRW-1:0] LAST = ADDRW'(SIZE - 1);
    localparam logic [CNTW-1:0]  CAP  = CNTW'(SIZE);

    // Advance a ring pointer, wrapping after the last entry.
    function automatic logic [ADDRW-1:0] wrap_inc(input logic [ADDRW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    logic [ADDRW-1:0] head_q, head_d;
    logic [ADDRW-1:0] tail_q, tail_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [SIZE-1:0]  busy_q, busy_d;
    logic [SIZE-1:0]  done_q, done_d;

    logic    alloc_fire;
    logic    deq_fire;
    cnt_op_e cnt_op;

    // Status and handshake outputs come from registered state only.
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CAP);
    assign alloc_ready_o = !full_o;
    assign alloc_tag_o   = tail_q;
    assign deq_valid_o   = !empty_o && done_q[head_q];
    assign deq_tag_o     = head_q;

    assign alloc_fire = alloc_valid_i && alloc_ready_o;
    assign deq_fire   = deq_valid_o && deq_ready_i;

    // Decide how occupancy moves this cycle.
    always_comb begin
        cnt_op = CNT_HOLD;
        unique case ({alloc_fire, deq_fire})
            2'b10:   cnt_op = CNT_INC;
            2'b01:   cnt_op = CNT_DEC;
            default: cnt_op = CNT_HOLD;
        endcase
    end

    // Next-state for pointers, count and per-entry flags. Legal traffic never
    // makes these updates collide on one entry; a fill is applied last so a
    // stray fill still leaves done set.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q;

        if (deq_fire) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = wrap_inc(head_q);
        end

        if (alloc_fire) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = wrap_inc(tail_q);
        end

        if (fill_valid_i) begin
            done_d[fill_tag_i] = 1'b1;
        end

        unique case (cnt_op)
            CNT_INC: count_d = count_q + 1'b1;
            CNT_DEC: count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    vx_reorder_buffer_dp_ram #(
        .DATAW  (DATAW),
        .SIZE   (SIZE),
        .ADDRW  (ADDRW),
        .LUTRAM (LUTRAM)
    ) u_store (
        .clk_i   (clk_i),
        .we_i    (fill_valid_i),
        .waddr_i (fill_tag_i),
        .wdata_i (fill_data_i),
        .raddr_i (head_q),
        .rdata_o (deq_data_o)
    );

    // A fill must name an entry that is outstanding and not yet completed.
    a_fill_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fill_valid_i |-> busy_q[fill_tag_i]);
    a_fill_once: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fill_valid_i |-> !done_q[fill_tag_i]);

endmodule

// File: tb/tb_vx_reorder_buffer.sv
// Directed self-checking bench for vx_reorder_buffer (SIZE=4, DATAW=8).
module tb_vx_reorder_buffer;

    localparam int DATAW = 8;
    localparam int SIZE  = 4;
    localparam int ADDRW = 2;

    logic             clk;
    logic             rst_n;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [ADDRW-1:0] alloc_tag;
    logic             fill_valid;
    logic [ADDRW-1:0] fill_tag;
    logic [DATAW-1:0] fill_data;
    logic             deq_valid;
    logic [ADDRW-1:0] deq_tag;
    logic [DATAW-1:0] deq_data;
    logic             deq_ready;
    logic             empty;
    logic             full;

    int checks   = 0;
    int failures = 0;

    vx_reorder_buffer #(
        .DATAW  (DATAW),
        .SIZE   (SIZE),
        .ADDRW  (ADDRW),
        .LUTRAM (1)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .alloc_valid_i (alloc_valid),
        .alloc_ready_o (alloc_ready),
        .alloc_tag_o   (alloc_tag),
        .fill_valid_i  (fill_valid),
        .fill_tag_i    (fill_tag),
        .fill_data_i   (fill_data),
        .deq_valid_o   (deq_valid),
        .deq_tag_o     (deq_tag),
        .deq_data_o    (deq_data),
        .deq_ready_i   (deq_ready),
        .empty_o       (empty),
        .full_o        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        fill_valid  = 1'b0;
        fill_tag    = '0;
        fill_data   = '0;
        deq_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // In-order fill
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1;
            #1;
            chk("inord_alloc_ready", alloc_ready, 1);
            chk("inord_alloc_tag", alloc_tag, i);
            tick();
        end
        alloc_valid = 1'b0;
        #1;
        chk("inord_full", full, 1);
        chk("inord_alloc_ready_full", alloc_ready, 0);
        for (int i = 0; i < 4; i++) begin
            fill_valid = 1'b1;
            fill_tag   = 2'(i);
            fill_data  = 8'(8'hA0 + i);
            tick();
        end
        fill_valid = 1'b0;
        deq_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("inord_deq_valid", deq_valid, 1);
            chk("inord_deq_tag", deq_tag, i);
            chk("inord_deq_data", deq_data, 8'hA0 + i);
            tick();
        end
        deq_ready = 1'b0;
        chk("inord_empty", empty, 1);
        chk("inord_deq_valid_end", deq_valid, 0);

        // Reversed fill
        alloc_valid = 1'b1;
        repeat (3) tick();
        alloc_valid = 1'b0;
        fill_valid  = 1'b1;
        fill_tag    = 2'd2;
        fill_data   = 8'h22;
        tick();
        chk("rev_hold_after_t2", deq_valid, 0);
        fill_tag  = 2'd1;
        fill_data = 8'h11;
        tick();
        chk("rev_hold_after_t1", deq_valid, 0);
        fill_tag  = 2'd0;
        fill_data = 8'h00;
        deq_ready = 1'b1;
        #1;
        chk("rev_head_fill_not_comb", deq_valid, 0);
        tick();
        fill_valid = 1'b0;
        chk("rev_deq0_valid", deq_valid, 1);
        chk("rev_deq0_tag", deq_tag, 0);
        chk("rev_deq0_data", deq_data, 8'h00);
        tick();
        chk("rev_deq1_valid", deq_valid, 1);
        chk("rev_deq1_tag", deq_tag, 1);
        chk("rev_deq1_data", deq_data, 8'h11);
        tick();
        chk("rev_deq2_valid", deq_valid, 1);
        chk("rev_deq2_tag", deq_tag, 2);
        chk("rev_deq2_data", deq_data, 8'h22);
        tick();
        deq_ready = 1'b0;
        chk("rev_empty", empty, 1);

        // Wrap-around at steady occupancy 2
        do_reset();
        for (int r = 0; r < 8; r++) begin
            alloc_valid = (r < 6);
            fill_valid  = (r >= 1) && (r <= 6);
            fill_tag    = 2'((r + 3) % 4);
            fill_data   = 8'(8'h30 + r - 1);
            deq_ready   = (r >= 2);
            #1;
            if (r < 6) begin
                chk("wrap_alloc_tag", alloc_tag, r % 4);
            end
            if (r >= 2) begin
                chk("wrap_deq_valid", deq_valid, 1);
                chk("wrap_deq_tag", deq_tag, (r - 2) % 4);
                chk("wrap_deq_data", deq_data, 8'h30 + r - 2);
            end
            tick();
            chk("wrap_count_le2", (dut.count_q <= 3'd2), 1);
        end
        idle();
        chk("wrap_empty", empty, 1);

        // Full with simultaneous dequeue
        do_reset();
        alloc_valid = 1'b1;
        repeat (4) tick();
        alloc_valid = 1'b0;
        fill_valid  = 1'b1;
        fill_tag    = 2'd0;
        fill_data   = 8'h44;
        tick();
        fill_valid = 1'b0;
        chk("fullsim_full", full, 1);
        alloc_valid = 1'b1;
        deq_ready   = 1'b1;
        #1;
        chk("fullsim_alloc_ready", alloc_ready, 0);
        chk("fullsim_deq_valid", deq_valid, 1);
        chk("fullsim_deq_data", deq_data, 8'h44);
        tick();
        alloc_valid = 1'b0;
        deq_ready   = 1'b0;
        chk("fullsim_alloc_ready_after", alloc_ready, 1);
        chk("fullsim_alloc_tag_after", alloc_tag, 0);
        chk("fullsim_full_after", full, 0);
        chk("fullsim_count_after", dut.count_q, 3);

        // Reset mid-run
        do_reset();
        alloc_valid = 1'b1;
        repeat (2) tick();
        alloc_valid = 1'b0;
        fill_valid  = 1'b1;
        fill_tag    = 2'd0;
        fill_data   = 8'h99;
        tick();
        fill_valid = 1'b0;
        chk("midrst_pre_valid", deq_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", dut.count_q, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_deq_valid", deq_valid, 0);
        chk("midrst_alloc_ready", alloc_ready, 1);
        chk("midrst_alloc_tag", alloc_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst_next_tag", alloc_tag, 0);
        chk("midrst_empty_after", empty, 1);

        // Fill at head under backpressure
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        fill_valid  = 1'b1;
        fill_tag    = 2'd0;
        fill_data   = 8'h5A;
        deq_ready   = 1'b0;
        #1;
        chk("bp_not_comb", deq_valid, 0);
        tick();
        fill_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", deq_valid, 1);
            chk("bp_hold_data", deq_data, 8'h5A);
            chk("bp_hold_tag", deq_tag, 0);
            tick();
        end
        deq_ready = 1'b1;
        #1;
        chk("bp_release_valid", deq_valid, 1);
        tick();
        deq_ready = 1'b0;
        chk("bp_empty", empty, 1);
        chk("bp_deq_valid_end", deq_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
